// File: rtl/secuenciador_fin_partida.sv
// End-of-game sequencer: freezes play on a round result, drives the winner timer, then clears the board.
// Optional score counters are built when SECUENCIADOR_MARCADOR_EN is defined.
module secuenciador_fin_partida #(
    parameter int BLINK_CYCLES = 6_293_750,
    parameter int MAX_PUNTOS   = 9
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gana_j1,
    input  logic       gana_j2,
    input  logic       tablero_lleno,
    input  logic       saltar,
    input  logic       timer_done,
    output logic       timer_en,
    output logic       jugando,
    output logic [1:0] resultado,
    output logic       parpadeo,
    output logic       limpiar,
    output logic [3:0] puntos_j1,
    output logic [3:0] puntos_j2
);

    localparam int CW = $clog2(BLINK_CYCLES);

    typedef enum logic [1:0] {
        JUGANDO = 2'd0,
        MOSTRAR = 2'd1,
        LIMPIAR = 2'd2
    } estado_t;

    estado_t       r_estado;
    estado_t       w_siguiente;
    logic          w_evento;
    logic          w_entra;
    logic [1:0]    w_codigo;
    logic [1:0]    r_resultado;
    logic          r_parpadeo;
    logic [CW-1:0] r_cnt;

    assign w_evento = gana_j1 | gana_j2 | tablero_lleno;
    assign w_entra  = (r_estado == JUGANDO) && w_evento;

    // Any win outranks a full board; two simultaneous wins count as a draw.
    always_comb begin
        w_codigo = 2'b11;
        if (gana_j1 && !gana_j2)
            w_codigo = 2'b01;
        else if (gana_j2 && !gana_j1)
            w_codigo = 2'b10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_estado <= JUGANDO;
        else
            r_estado <= w_siguiente;
    end

    always_comb begin
        w_siguiente = r_estado;
        timer_en    = 1'b0;
        jugando     = 1'b0;
        limpiar     = 1'b0;
        case (r_estado)
            JUGANDO: begin
                jugando = 1'b1;
                if (w_evento)
                    w_siguiente = MOSTRAR;
            end
            MOSTRAR: begin
                timer_en = 1'b1;
                if (timer_done || saltar)
                    w_siguiente = LIMPIAR;
            end
            LIMPIAR: begin
                limpiar     = 1'b1;
                w_siguiente = JUGANDO;
            end
            default: w_siguiente = JUGANDO;
        endcase
    end

    // Result and blink are cleared on the way into LIMPIAR so the clear cycle already shows 00/0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_resultado <= 2'b00;
            r_parpadeo  <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_estado)
                JUGANDO: begin
                    r_cnt <= '0;
                    if (w_entra) begin
                        r_resultado <= w_codigo;
                        r_parpadeo  <= 1'b1;
                    end
                end
                MOSTRAR: begin
                    if (w_siguiente != MOSTRAR) begin
                        r_resultado <= 2'b00;
                        r_parpadeo  <= 1'b0;
                        r_cnt       <= '0;
                    end else if (r_cnt == CW'(BLINK_CYCLES - 1)) begin
                        r_cnt      <= '0;
                        r_parpadeo <= ~r_parpadeo;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_resultado <= 2'b00;
                    r_parpadeo  <= 1'b0;
                    r_cnt       <= '0;
                end
            endcase
        end
    end

    assign resultado = r_resultado;
    assign parpadeo  = r_parpadeo;

`ifdef SECUENCIADOR_MARCADOR_EN
    logic [3:0] r_puntos_j1;
    logic [3:0] r_puntos_j2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_puntos_j1 <= 4'd0;
            r_puntos_j2 <= 4'd0;
        end else if (w_entra) begin
            if (w_codigo == 2'b01 && r_puntos_j1 < 4'(MAX_PUNTOS))
                r_puntos_j1 <= r_puntos_j1 + 4'd1;
            if (w_codigo == 2'b10 && r_puntos_j2 < 4'(MAX_PUNTOS))
                r_puntos_j2 <= r_puntos_j2 + 4'd1;
        end
    end

    assign puntos_j1 = r_puntos_j1;
    assign puntos_j2 = r_puntos_j2;
`else
    // Saturation value is referenced but masked so the interface stays identical without the scoreboard.
    assign puntos_j1 = 4'(MAX_PUNTOS) & 4'h0;
    assign puntos_j2 = 4'(MAX_PUNTOS) & 4'h0;
`endif

endmodule

// File: tb/tb_secuenciador_fin_partida.sv
// Scoreboard bench for secuenciador_fin_partida: stimulus pushes expected round results,
// a negedge monitor pops them when the DUT enters its display phase.
module tb_secuenciador_fin_partida;

    localparam int BLINK = 4;
    localparam int MAXP  = 9;
`ifdef SECUENCIADOR_MARCADOR_EN
    localparam bit MARC = 1'b1;
`else
    localparam bit MARC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, gana_j1, gana_j2, tablero_lleno, saltar, timer_done;
    logic       timer_en, jugando, parpadeo, limpiar;
    logic [1:0] resultado;
    logic [3:0] puntos_j1, puntos_j2;

    secuenciador_fin_partida #(.BLINK_CYCLES(BLINK), .MAX_PUNTOS(MAXP)) dut (
        .clk(clk), .reset(reset), .gana_j1(gana_j1), .gana_j2(gana_j2),
        .tablero_lleno(tablero_lleno), .saltar(saltar), .timer_done(timer_done),
        .timer_en(timer_en), .jugando(jugando), .resultado(resultado),
        .parpadeo(parpadeo), .limpiar(limpiar), .puntos_j1(puntos_j1), .puntos_j2(puntos_j2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] res;
        logic [3:0] p1;
        logic [3:0] p2;
    } esperado_t;

    esperado_t q[$];
    int total = 0, bad = 0;
    int m_p1 = 0, m_p2 = 0;
    int n_fin = 0, n_limp = 0;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic ciclo();
        @(posedge clk);
        #1;
    endtask

    // Reference model: classify the event and update saturating scores.
    task automatic push_ronda(input logic g1, input logic g2, input logic ll);
        esperado_t e;
        if (g1 && g2)  e.res = 2'b11;
        else if (g1)   e.res = 2'b01;
        else if (g2)   e.res = 2'b10;
        else           e.res = 2'b11;
        if (e.res == 2'b01) m_p1 = (m_p1 + 1 > MAXP) ? MAXP : m_p1 + 1;
        if (e.res == 2'b10) m_p2 = (m_p2 + 1 > MAXP) ? MAXP : m_p2 + 1;
        e.p1 = MARC ? 4'(m_p1) : 4'd0;
        e.p2 = MARC ? 4'(m_p2) : 4'd0;
        q.push_back(e);
    endtask

    // One full round: event for one cycle, dur display cycles with ignored noise, then done/skip.
    task automatic ronda(input logic g1, input logic g2, input logic ll, input int dur,
                         input logic usa_done, input logic usa_saltar, input bit ruido);
        gana_j1 = g1; gana_j2 = g2; tablero_lleno = ll;
        push_ronda(g1, g2, ll);
        ciclo();
        gana_j1 = 0; gana_j2 = 0; tablero_lleno = 0;
        for (int i = 0; i < dur; i++) begin
            if (ruido) begin
                gana_j1 = 1'($urandom_range(0, 1));
                gana_j2 = 1'($urandom_range(0, 1));
                tablero_lleno = 1'($urandom_range(0, 1));
            end
            ciclo();
        end
        gana_j1 = 0; gana_j2 = 0; tablero_lleno = 0;
        timer_done = usa_done; saltar = usa_saltar;
        ciclo();
        timer_done = 0; saltar = 0;
        n_fin++;
        ciclo();
    endtask

    // Monitor: pop on display entry, track blink phase, validate the clear pulse.
    initial begin
        logic prev_en = 1'b0, prev_limp = 1'b0;
        int k = 0;
        esperado_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 1'b0; prev_limp = 1'b0;
            end else begin
                if (timer_en && !prev_en) begin
                    k = 0;
                    if (q.size() == 0) begin
                        chk("round_unexpected", 8'd1, 8'd0);
                    end else begin
                        e = q.pop_front();
                        chk("resultado", {6'd0, resultado}, {6'd0, e.res});
                        chk("puntos_j1", {4'd0, puntos_j1}, {4'd0, e.p1});
                        chk("puntos_j2", {4'd0, puntos_j2}, {4'd0, e.p2});
                    end
                end
                if (timer_en) begin
                    chk("parpadeo", {7'd0, parpadeo}, {7'd0, ((k / BLINK) % 2) == 0});
                    chk("jugando_in_show", {7'd0, jugando}, 8'd0);
                    k++;
                end
                if (limpiar) begin
                    n_limp++;
                    chk("limp_resultado", {6'd0, resultado}, 8'd0);
                    chk("limp_parpadeo", {7'd0, parpadeo}, 8'd0);
                    chk("limp_timer_en", {7'd0, timer_en}, 8'd0);
                end
                if (prev_limp) begin
                    chk("after_limp_jugando", {7'd0, jugando}, 8'd1);
                    chk("after_limp_limpiar", {7'd0, limpiar}, 8'd0);
                end
                prev_en = timer_en;
                prev_limp = limpiar;
            end
        end
    end

    initial begin
        reset = 1; gana_j1 = 0; gana_j2 = 0; tablero_lleno = 0; saltar = 0; timer_done = 0;
        #3;
        chk("rst_jugando", {7'd0, jugando}, 8'd1);
        chk("rst_timer_en", {7'd0, timer_en}, 8'd0);
        chk("rst_resultado", {6'd0, resultado}, 8'd0);
        chk("rst_limpiar", {7'd0, limpiar}, 8'd0);
        chk("rst_parpadeo", {7'd0, parpadeo}, 8'd0);
        ciclo();
        reset = 0;
        ciclo();

        // Stale done while playing must be ignored.
        timer_done = 1; ciclo(); timer_done = 0; ciclo();

        ronda(1, 0, 0, 10, 1, 0, 0);   // player 1 win, full blink pattern
        ronda(1, 1, 0, 3, 1, 0, 1);    // double win draws
        ronda(0, 1, 1, 2, 1, 1, 0);    // win beats full board; done+skip together
        ronda(0, 0, 1, 4, 0, 1, 1);    // full board draw
        ronda(1, 0, 0, 2, 0, 1, 1);    // skip 3 cycles into display
        for (int i = 0; i < 12; i++)
            ronda(0, 1, 0, $urandom_range(0, 3), 1, 0, 0);
        chk("sat_p2", {4'd0, puntos_j2}, MARC ? 8'(MAXP) : 8'd0);

        for (int i = 0; i < 25; i++) begin
            logic g1, g2, ll, d, s;
            g1 = 1'($urandom_range(0, 1));
            g2 = 1'($urandom_range(0, 1));
            ll = 1'($urandom_range(0, 1));
            if (!g1 && !g2 && !ll) ll = 1;
            d = 1'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            if (!d && !s) d = 1;
            ronda(g1, g2, ll, $urandom_range(0, 12), d, s, 1);
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                timer_done = 1'($urandom_range(0, 1));
                ciclo();
            end
            timer_done = 0;
        end

        // Asynchronous reset in the middle of a display phase.
        gana_j1 = 1; push_ronda(1, 0, 0); ciclo(); gana_j1 = 0;
        ciclo(); ciclo();
        #2 reset = 1;
        #1;
        chk("midrst_jugando", {7'd0, jugando}, 8'd1);
        chk("midrst_timer_en", {7'd0, timer_en}, 8'd0);
        chk("midrst_resultado", {6'd0, resultado}, 8'd0);
        chk("midrst_limpiar", {7'd0, limpiar}, 8'd0);
        chk("midrst_p1", {4'd0, puntos_j1}, 8'd0);
        chk("midrst_p2", {4'd0, puntos_j2}, 8'd0);
        m_p1 = 0; m_p2 = 0;
        ciclo();
        reset = 0;
        ciclo();
        ronda(0, 1, 0, 1, 1, 0, 0);
        ciclo(); ciclo();

        chk("queue_empty", 8'(q.size()), 8'd0);
        chk("limpiar_count", 8'(n_limp), 8'(n_fin));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
